fdd_dpll: RTL and testbench
===========================

// Module: fdd_dpll
// PURPOSE
//  Parametrised floppy read-data separator (digital PLL) for the VG93/WD1793 core.
//  Synchronises and deglitches raw drive RDAT, emits a fixed-width RAWR pulse, and runs a
//  proportional-correction phase counter that generates the RCLK window clock.
//  Adds FM/MFM rate select, configurable filter, gain and lock detection. Sits between FDD pins and vg93.
// PARAMETERS
//  CW        7    phase counter width in bits; must hold HALF_FM-1
//  HALF_MFM  56   fclk cycles per RCLK half-period in MFM mode (250 kbps at 28 MHz)
//  HALF_FM   112  fclk cycles per RCLK half-period in FM mode
//  FILT_LEN  4    consecutive equal samples required to accept an RDAT level
//  RAWR_LEN  4    vg_rawr low-pulse length in fclk cycles
//  KP_SHIFT  1    phase-error arithmetic right shift (loop gain 2^-KP_SHIFT)
//  WIN       8    |phase error| at or below this counts as an in-window edge
//  LOCK_CNT  16   consecutive in-window edges required to assert locked
// PORTS
//  fclk      in   1     system clock
//  rst_n     in   1     asynchronous active-low reset
//  rdat_n    in   1     raw drive read data, active low, asynchronous
//  mode_mfm  in   1     1 = MFM (HALF_MFM), 0 = FM (HALF_FM); quasi-static
//  vg_rclk   out  1     window clock to vg93; toggles every half-period
//  vg_rawr   out  1     active-low read pulse to vg93
//  locked    out  1     PLL in lock
//  phase_err out  CW+1  signed error latched at the last accepted edge (debug)
// BEHAVIOUR
//  Reset values: vg_rclk=0, vg_rawr=1, locked=0, phase_err=0, counter=0, lock count=0.
//   Sync flops and filtered level reset to 1 (idle).
//  Input: 2-flop synchroniser feeds a FILT_LEN-deep shift register. The filtered level takes
//   the register value only when all bits are equal; otherwise it holds.
//  Edge: 1->0 transition of the filtered level produces a one-cycle edge strobe.
//  RAWR: the cycle after the strobe, vg_rawr goes low for exactly RAWR_LEN cycles.
//   A strobe during a pulse restarts the pulse length.
//   Latency from a clean rdat_n fall to vg_rawr low is 2+FILT_LEN+2 fclk (8 at defaults).
//  Phase counter: P = mode_mfm ? HALF_MFM : HALF_FM; C = P/2-1 (27 for MFM, 55 for FM).
//   err = C - counter, computed signed in CW+1 bits; inc = strobe ? (err >>> KP_SHIFT) : 1.
//   If counter >= P-1: counter<=0, vg_rclk toggles. Wrap has priority: a strobe in the
//   same cycle loses its correction, but lock accounting still uses it.
//   Otherwise counter <= counter+inc, clamped to 0 if negative and to P-1 if above.
//  phase_err <= err on every strobe.
//  Lock: on a strobe with |err| <= WIN, the saturating good-edge count increments;
//   locked=1 once the count reaches LOCK_CNT.
//   A strobe with |err| > WIN clears the count and locked in the next cycle.
//   No edges means no change.
//  Mode change: a mode_mfm change seen (registered copy differs) clears counter, lock count
//   and locked in the next cycle. vg_rclk keeps its level; the new period starts from 0.
//  Async reset mid-pulse or mid-period forces all reset values immediately. First edge after
//   release behaves as in normal operation.
// STRUCTURE
//  fdd_defs.vh: mode encodings and default HALF_MFM, HALF_FM, WIN, LOCK_CNT constants,
//   shared with vg93 top.
//  Sub-module fdd_rdat_filter: synchroniser, FILT_LEN filter and edge strobe. Reused by the
//   index-pulse path.
//  Top holds the RAWR stretcher, phase counter, lock logic and mode tracking.
// TESTING
//  Free-run, MFM, no edges -> vg_rclk toggles every 56 fclk (period 112); locked stays 0.
//  rdat_n low for 2 fclk, then high -> no strobe, vg_rawr stays 1.
//   rdat_n low for 6 fclk -> vg_rawr low 4 cycles, starting 8 cycles after the fall.
//  Edge lands with counter=43 -> err=-16, inc=-8, counter 35 next cycle, phase_err=-16.
//   Edge at counter=11 -> inc=+8.
//  20 edges every 112 fclk on counter=27 -> locked=1 after the 16th edge.
//   Then one edge at counter=50 -> locked=0 next cycle.
//  Edge in the wrap cycle (counter=55) -> counter=0, vg_rclk toggles, no correction applied.
//  Switch mode_mfm 1->0 while locked -> locked=0, counter=0.
//   Following half-periods are 112 fclk; rst_n pulse mid-pulse -> vg_rawr=1 immediately.

Source files
------------

// File: rtl/fdd_dpll_pkg.sv
// Shared definitions for the floppy read-data separator: mode encodings and
// the default timing constants also used by the vg93 top level.
package fdd_dpll_pkg;

    // Data-rate mode as presented on mode_mfm.
    typedef enum logic {
        MODE_FM  = 1'b0,
        MODE_MFM = 1'b1
    } mode_t;

    // Default loop timing at a 28 MHz fclk.
    localparam int DEF_HALF_MFM = 56;
    localparam int DEF_HALF_FM  = 112;
    localparam int DEF_WIN      = 8;
    localparam int DEF_LOCK_CNT = 16;

endpackage : fdd_dpll_pkg

// File: rtl/fdd_rdat_filter.sv
// Read-data conditioner: two-flop synchroniser, FILT_LEN-deep majority-free
// glitch filter (level changes only when every sample agrees) and a one-cycle
// strobe on each accepted 1->0 transition. Also used on the index-pulse path.
module fdd_rdat_filter #(
    parameter int FILT_LEN = 4
) (
    input  logic fclk,
    input  logic rst_n,
    input  logic rdat_n,
    output logic strobe
);

    logic [1:0]          sync_reg;
    logic [FILT_LEN-1:0] shift_reg;
    logic [FILT_LEN-1:0] shift_next;
    logic                level_reg;
    logic                all_low;
    logic                all_high;

    // Shift path built bit by bit so FILT_LEN=1 still elaborates.
    assign shift_next[0] = sync_reg[1];
    generate
        for (genvar gi = 1; gi < FILT_LEN; gi++) begin : g_shift
            assign shift_next[gi] = shift_reg[gi-1];
        end
    endgenerate

    assign all_low  = ~|shift_reg;
    assign all_high = &shift_reg;

    // Synchronise, filter and flag the accepted falling edge of the level.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b11;
            shift_reg <= '1;
            level_reg <= 1'b1;
            strobe    <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], rdat_n};
            shift_reg <= shift_next;
            if (all_high) begin
                level_reg <= 1'b1;
            end else if (all_low) begin
                level_reg <= 1'b0;
            end
            strobe <= level_reg & all_low;
        end
    end

endmodule : fdd_rdat_filter

// File: rtl/fdd_dpll.sv
// Floppy read-data separator (digital PLL) between the drive pins and vg93.
// Produces the RAWR pulse from accepted RDAT edges and a window clock RCLK
// from a phase counter that is nudged toward the half-period centre by a
// fraction of the measured phase error at each edge.
module fdd_dpll
    import fdd_dpll_pkg::*;
#(
    parameter int CW       = 7,
    parameter int HALF_MFM = DEF_HALF_MFM,
    parameter int HALF_FM  = DEF_HALF_FM,
    parameter int FILT_LEN = 4,
    parameter int RAWR_LEN = 4,
    parameter int KP_SHIFT = 1,
    parameter int WIN      = DEF_WIN,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic                 fclk,
    input  logic                 rst_n,
    input  logic                 rdat_n,
    input  logic                 mode_mfm,
    output logic                 vg_rclk,
    output logic                 vg_rawr,
    output logic                 locked,
    output logic signed [CW:0]   phase_err
);

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(RAWR_LEN + 1);
    localparam logic signed [CW:0] ONE = 1;

    logic                 strobe;
    logic [CW-1:0]        cnt_reg;
    logic [CW-1:0]        cnt_next;
    logic [CW-1:0]        last_idx;
    logic [CW-1:0]        center;
    logic signed [CW:0]   err;
    logic [CW:0]          err_mag;
    logic signed [CW:0]   inc;
    logic signed [CW+1:0] sum;
    logic                 in_win;
    logic                 mode_change;
    mode_t                mode_reg;
    logic [LW-1:0]        good_reg;
    logic [RW-1:0]        rawr_reg;

    fdd_rdat_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_filter (
        .fclk   (fclk),
        .rst_n  (rst_n),
        .rdat_n (rdat_n),
        .strobe (strobe)
    );

    assign last_idx    = mode_mfm ? CW'(HALF_MFM - 1) : CW'(HALF_FM - 1);
    assign center      = mode_mfm ? CW'(HALF_MFM / 2 - 1) : CW'(HALF_FM / 2 - 1);
    assign err         = $signed({1'b0, center}) - $signed({1'b0, cnt_reg});
    assign err_mag     = err[CW] ? $unsigned(-err) : $unsigned(err);
    assign in_win      = err_mag <= (CW+1)'(WIN);
    assign inc         = strobe ? (err >>> KP_SHIFT) : ONE;
    assign sum         = $signed({2'b00, cnt_reg}) + $signed({inc[CW], inc});
    assign mode_change = mode_reg != mode_t'(mode_mfm);

    // Corrected counter value, kept inside the current half-period.
    always_comb begin
        cnt_next = sum[CW-1:0];
        if (sum < 0) begin
            cnt_next = '0;
        end else if (sum > $signed({2'b00, last_idx})) begin
            cnt_next = last_idx;
        end
    end

    // RAWR stretcher: a new strobe always restarts the full low pulse.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            rawr_reg <= '0;
            vg_rawr  <= 1'b1;
        end else if (strobe) begin
            rawr_reg <= RW'(RAWR_LEN);
            vg_rawr  <= 1'b0;
        end else if (rawr_reg > RW'(1)) begin
            rawr_reg <= rawr_reg - RW'(1);
            vg_rawr  <= 1'b0;
        end else begin
            rawr_reg <= '0;
            vg_rawr  <= 1'b1;
        end
    end

    // Phase counter, window clock, lock tracking and mode-change restart.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            vg_rclk   <= 1'b0;
            good_reg  <= '0;
            locked    <= 1'b0;
            phase_err <= '0;
            mode_reg  <= MODE_MFM;
        end else begin
            mode_reg <= mode_t'(mode_mfm);
            if (strobe) begin
                phase_err <= err;
            end
            if (mode_change) begin
                // New rate: restart the period from zero, keep the RCLK level.
                cnt_reg  <= '0;
                good_reg <= '0;
                locked   <= 1'b0;
            end else begin
                // Wrap wins over correction; an edge here only affects lock.
                if (cnt_reg >= last_idx) begin
                    cnt_reg <= '0;
                    vg_rclk <= ~vg_rclk;
                end else begin
                    cnt_reg <= cnt_next;
                end
                if (strobe) begin
                    if (in_win) begin
                        if (good_reg != LW'(LOCK_CNT)) begin
                            good_reg <= good_reg + LW'(1);
                        end
                        if (good_reg >= LW'(LOCK_CNT - 1)) begin
                            locked <= 1'b1;
                        end
                    end else begin
                        good_reg <= '0;
                        locked   <= 1'b0;
                    end
                end
            end
        end
    end

endmodule : fdd_dpll

// File: tb/tb_fdd_dpll.sv
// Scoreboard bench for fdd_dpll: a cycle-level arithmetic model predicts
// each RAWR pulse (time, latched error, lock state) and each RCLK toggle;
// a monitor pops and compares whenever the DUT shows one.
module tb_fdd_dpll;

    logic              fclk = 1'b0;
    logic              rst_n = 1'b1;
    logic              rdat_n = 1'b1;
    logic              mode_mfm = 1'b1;
    logic              vg_rclk;
    logic              vg_rawr;
    logic              locked;
    logic signed [7:0] phase_err;

    fdd_dpll dut (
        .fclk      (fclk),
        .rst_n     (rst_n),
        .rdat_n    (rdat_n),
        .mode_mfm  (mode_mfm),
        .vg_rclk   (vg_rclk),
        .vg_rawr   (vg_rawr),
        .locked    (locked),
        .phase_err (phase_err)
    );

    always #5 fclk = ~fclk;

    int cyc = 0;
    always @(posedge fclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    typedef struct {
        int cyc;
        int perr;
        int lock;
    } rawr_exp_t;

    rawr_exp_t rawr_q[$];
    int        rclk_q[$];
    int        pend_q[$];
    bit        mon_en = 1'b0;

    // Behavioural model state
    int m_cnt = 0, m_rclk = 0, m_good = 0, m_locked = 0, m_mode_prev = 1;
    int high_run = 0;

    function automatic int half_div(int e);
        return (e >= 0) ? e / 2 : -((1 - e) / 2);
    endfunction

    // Advance the model across the clock edge just taken.
    function automatic void model_edge();
        int p, c, err, inc, nxt;
        bit stb;
        p   = mode_mfm ? 56 : 112;
        c   = p / 2 - 1;
        err = c - m_cnt;
        stb = 1'b0;
        if (pend_q.size() > 0 && pend_q[0] == cyc) begin
            stb = 1'b1;
            void'(pend_q.pop_front());
        end
        if (int'(mode_mfm) != m_mode_prev) begin
            m_cnt = 0; m_good = 0; m_locked = 0;
        end else begin
            if (m_cnt >= p - 1) begin
                m_cnt = 0;
                m_rclk ^= 1;
                rclk_q.push_back(cyc);
            end else begin
                inc = stb ? half_div(err) : 1;
                nxt = m_cnt + inc;
                if (nxt < 0) nxt = 0;
                if (nxt > p - 1) nxt = p - 1;
                m_cnt = nxt;
            end
            if (stb) begin
                if (err <= 8 && err >= -8) begin
                    if (m_good < 16) m_good++;
                    if (m_good >= 16) m_locked = 1;
                end else begin
                    m_good = 0; m_locked = 0;
                end
            end
        end
        m_mode_prev = int'(mode_mfm);
        if (stb) rawr_q.push_back('{cyc, err, m_locked});
    endfunction

    task automatic step();
        @(posedge fclk);
        #1;
        model_edge();
        if (rdat_n) high_run++;
        else high_run = 0;
    endtask

    // Drop rdat_n so the accepted edge lands when the counter reads target.
    task automatic edge_at(input int target, input int low_len);
        int guard;
        guard = 0;
        while (!((((m_cnt + 7) % (mode_mfm ? 56 : 112)) == target) &&
                 high_run >= 10 && pend_q.size() == 0)) begin
            step();
            guard++;
            if (guard > 2000) begin
                chk("edge_at_timeout", guard, 0);
                return;
            end
        end
        rdat_n = 1'b0;
        pend_q.push_back(cyc + 8);
        repeat (low_len) step();
        rdat_n = 1'b1;
    endtask

    task automatic glitch(input int len);
        while (high_run < 10) step();
        rdat_n = 1'b0;
        repeat (len) step();
        rdat_n = 1'b1;
    endtask

    // Monitor: compare every RAWR fall and RCLK toggle against the scoreboard.
    initial begin : monitor
        bit        prev_rawr;
        bit        prev_rclk;
        int        low_cnt;
        rawr_exp_t e;
        prev_rawr = 1'b1;
        prev_rclk = 1'b0;
        low_cnt   = 0;
        forever begin
            @(negedge fclk);
            if (mon_en) begin
                if (prev_rawr && !vg_rawr) begin
                    if (rawr_q.size() == 0) begin
                        chk("rawr_unexpected", cyc, -1);
                    end else begin
                        e = rawr_q.pop_front();
                        chk("rawr_cycle", cyc, e.cyc);
                        chk("phase_err", int'(phase_err), e.perr);
                        chk("locked_at_edge", int'(locked), e.lock);
                    end
                    low_cnt = 0;
                end
                if (!vg_rawr) low_cnt++;
                if (!prev_rawr && vg_rawr) chk("rawr_width", low_cnt, 4);
                if (vg_rclk != prev_rclk) begin
                    if (rclk_q.size() == 0) chk("rclk_unexpected", cyc, -1);
                    else chk("rclk_toggle", cyc, rclk_q.pop_front());
                end
            end
            prev_rawr = vg_rawr;
            prev_rclk = vg_rclk;
        end
    end

    // Stimulus
    initial begin : stim
        int p;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_rclk", int'(vg_rclk), 0);
        chk("reset_rawr", int'(vg_rawr), 1);
        chk("reset_locked", int'(locked), 0);
        chk("reset_perr", int'(phase_err), 0);
        repeat (3) @(posedge fclk);
        @(negedge fclk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        repeat (300) step();            // free-run MFM
        glitch(2);                      // too short to be accepted
        repeat (20) step();

        edge_at(43, 6);
        repeat (4) step();
        chk("perr_late_edge", int'(phase_err), -16);

        edge_at(11, 6);
        repeat (4) step();
        chk("perr_early_edge", int'(phase_err), 16);

        repeat (20) edge_at(27, 6);
        repeat (10) step();
        chk("locked_after_20", int'(locked), 1);

        edge_at(50, 6);
        repeat (4) step();
        chk("unlock_bad_edge", int'(locked), 0);

        edge_at(55, 6);                 // edge on the wrap cycle
        repeat (10) step();

        repeat (16) edge_at(27, 7);
        repeat (10) step();
        chk("relocked", int'(locked), 1);
        mode_mfm = 1'b0;
        step();
        chk("mode_switch_unlock", int'(locked), 0);
        repeat (300) step();            // FM half-periods

        for (int i = 0; i < 30; i++) begin
            if (i == 15) begin
                while (pend_q.size() != 0) step();
                repeat (10) step();
                mode_mfm = 1'b1;
                step();
            end
            p = mode_mfm ? 56 : 112;
            if ($urandom_range(0, 3) == 0) glitch($urandom_range(1, 2));
            if ($urandom_range(0, 1) == 1)
                edge_at(p / 2 - 1 + $urandom_range(0, 16) - 8, $urandom_range(5, 9));
            else
                edge_at($urandom_range(0, p - 1), $urandom_range(5, 9));
        end

        repeat (40) step();
        chk("rawr_queue_drained", rawr_q.size(), 0);
        chk("rclk_queue_drained", int'(rclk_q.size() > 1), 0);

        edge_at(20, 6);
        repeat (3) step();
        chk("rawr_low_before_reset", int'(vg_rawr), 0);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midpulse_reset_rawr", int'(vg_rawr), 1);
        chk("midpulse_reset_rclk", int'(vg_rclk), 0);
        chk("midpulse_reset_locked", int'(locked), 0);
        chk("midpulse_reset_perr", int'(phase_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fdd_dpll
